usbdev_line_event_det: RTL and testbench

Line-state event detector for the USB device, consuming the synchronized `usb_rx_dp`/`usb_rx_dn`/`usb_pwr_sense` signals produced by the USB IO mux in the USB clock domain. It filters raw D+/D- into a debounced line state, times J/K/SE0 intervals against a 1 µs tick, and tracks the link through disconnect, active, bus-reset, suspend and resume. Single-cycle event pulses and level status feed the link-state logic and interrupt sources.

---
 rtl/usbdev_line_event_det.sv | 190 +++++++++++++++++++
 tb/tb_usbdev_line_event_det.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usbdev_line_event_det.sv
// USB device line-state event detector: debounces D+/D-, times line intervals on a 1 us tick
// and tracks disconnect/active/reset/suspend/resume. SE1 error flag enabled by USBDEV_LINE_EVENT_SE1_ERR_EN.
module usbdev_line_event_det #(
  parameter int unsigned FiltCycles = 3,
  parameter int unsigned ResetUs    = 3,
  parameter int unsigned SuspendUs  = 3000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       usb_rx_dp_i,
  input  logic       usb_rx_dn_i,
  input  logic       usb_pwr_sense_i,
  input  logic       rx_enable_i,
  input  logic       us_tick_i,
  input  logic       se1_clr_i,
  output logic [1:0] line_state_o,
  output logic [2:0] link_state_o,
  output logic       bus_reset_o,
  output logic       suspend_o,
  output logic       evt_reset_o,
  output logic       evt_suspend_o,
  output logic       evt_resume_o,
  output logic       evt_disconnect_o,
  output logic       se1_err_o
);

  localparam int unsigned TimerW = $clog2(SuspendUs + 1);
  localparam int unsigned CntW   = $clog2(FiltCycles + 1);

  localparam logic [TimerW-1:0] TimerMax   = '1;
  localparam logic [TimerW-1:0] ResetThr   = TimerW'(ResetUs);
  localparam logic [TimerW-1:0] SuspendThr = TimerW'(SuspendUs);
  localparam logic [CntW-1:0]   FiltMax    = CntW'(FiltCycles);

  localparam logic [1:0] LineSe0 = 2'd0;
  localparam logic [1:0] LineJ   = 2'd1;
  localparam logic [1:0] LineK   = 2'd2;
  localparam logic [1:0] LineSe1 = 2'd3;

  typedef enum logic [2:0] {
    LinkDisconnected = 3'd0,
    LinkActive       = 3'd1,
    LinkReset        = 3'd2,
    LinkSuspended    = 3'd3,
    LinkResuming     = 3'd4
  } link_e;

  logic [1:0]        raw;
  logic [1:0]        cand_q, cand_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        line_q, line_d;
  logic [TimerW-1:0] timer_q, timer_d;
  link_e             link_q, link_d;
  logic              bus_reset_q, bus_reset_d;
  logic              suspend_q, suspend_d;
  logic              evt_reset_q, evt_reset_d;
  logic              evt_suspend_q, evt_suspend_d;
  logic              evt_resume_q, evt_resume_d;
  logic              evt_disc_q, evt_disc_d;

  assign raw = {usb_rx_dn_i, usb_rx_dp_i};

  // Debounce: the filtered state follows the candidate once it has been stable FiltCycles samples
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    line_d = line_q;
    if (raw != cand_q) begin
      cand_d = raw;
      cnt_d  = CntW'(1);
    end else if (cnt_q < FiltMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if ((raw == cand_q) && (cnt_d == FiltMax)) begin
      line_d = cand_q;
    end
  end

  // Link state machine; power/enable loss overrides every other transition
  always_comb begin
    link_d        = link_q;
    evt_reset_d   = 1'b0;
    evt_suspend_d = 1'b0;
    evt_resume_d  = 1'b0;
    evt_disc_d    = 1'b0;
    if (!usb_pwr_sense_i || !rx_enable_i) begin
      link_d     = LinkDisconnected;
      evt_disc_d = (link_q != LinkDisconnected);
    end else begin
      unique case (link_q)
        LinkDisconnected: link_d = LinkActive;
        LinkReset: begin
          if (line_q != LineSe0) link_d = LinkActive;
        end
        LinkActive, LinkSuspended, LinkResuming: begin
          if ((line_q == LineSe0) && (timer_q >= ResetThr)) begin
            link_d      = LinkReset;
            evt_reset_d = 1'b1;
          end else if (link_q == LinkActive) begin
            if ((line_q == LineJ) && (timer_q >= SuspendThr)) begin
              link_d        = LinkSuspended;
              evt_suspend_d = 1'b1;
            end
          end else if (link_q == LinkSuspended) begin
            if (line_q == LineK) link_d = LinkResuming;
          end else begin
            if ((line_q == LineSe0) || (line_q == LineJ)) begin
              link_d       = LinkActive;
              evt_resume_d = 1'b1;
            end
          end
        end
        default: link_d = LinkDisconnected;
      endcase
    end
  end

  // Interval timer restarts whenever the filtered line or the link state moves
  always_comb begin
    timer_d = timer_q;
    if ((line_d != line_q) || (link_d != link_q)) begin
      timer_d = '0;
    end else if (us_tick_i && (timer_q != TimerMax)) begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  assign bus_reset_d = (link_d == LinkReset);
  assign suspend_d   = (link_d == LinkSuspended) || (link_d == LinkResuming);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cand_q        <= LineSe0;
      cnt_q         <= '0;
      line_q        <= LineSe0;
      timer_q       <= '0;
      link_q        <= LinkDisconnected;
      bus_reset_q   <= 1'b0;
      suspend_q     <= 1'b0;
      evt_reset_q   <= 1'b0;
      evt_suspend_q <= 1'b0;
      evt_resume_q  <= 1'b0;
      evt_disc_q    <= 1'b0;
    end else begin
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      line_q        <= line_d;
      timer_q       <= timer_d;
      link_q        <= link_d;
      bus_reset_q   <= bus_reset_d;
      suspend_q     <= suspend_d;
      evt_reset_q   <= evt_reset_d;
      evt_suspend_q <= evt_suspend_d;
      evt_resume_q  <= evt_resume_d;
      evt_disc_q    <= evt_disc_d;
    end
  end

`ifdef USBDEV_LINE_EVENT_SE1_ERR_EN
  logic se1_err_q;

  // Sticky SE1 flag; a new SE1 observation wins over a simultaneous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      se1_err_q <= 1'b0;
    end else if (line_q == LineSe1) begin
      se1_err_q <= 1'b1;
    end else if (se1_clr_i) begin
      se1_err_q <= 1'b0;
    end
  end

  assign se1_err_o = se1_err_q;
`else
  logic unused_se1_clr;

  assign unused_se1_clr = se1_clr_i;
  assign se1_err_o      = 1'b0;
`endif

  assign line_state_o     = line_q;
  assign link_state_o     = link_q;
  assign bus_reset_o      = bus_reset_q;
  assign suspend_o        = suspend_q;
  assign evt_reset_o      = evt_reset_q;
  assign evt_suspend_o    = evt_suspend_q;
  assign evt_resume_o     = evt_resume_q;
  assign evt_disconnect_o = evt_disc_q;

endmodule

// File: tb/tb_usbdev_line_event_det.sv
// Scoreboard bench for usbdev_line_event_det: every change of the observable outputs is
// matched in order against hand-computed expectations, including tick counts for timed transitions.
module tb_usbdev_line_event_det;

  localparam int TickP = 8;

  localparam logic [1:0] Se0 = 2'd0;
  localparam logic [1:0] J   = 2'd1;
  localparam logic [1:0] K   = 2'd2;
  localparam logic [1:0] Se1 = 2'd3;

  localparam logic [2:0] Disc = 3'd0;
  localparam logic [2:0] Act  = 3'd1;
  localparam logic [2:0] Rst  = 3'd2;
  localparam logic [2:0] Susp = 3'd3;
  localparam logic [2:0] Resm = 3'd4;

  // evt vector order: {disconnect, resume, suspend, reset}
  localparam logic [3:0] EvNone = 4'b0000;
  localparam logic [3:0] EvRst  = 4'b0001;
  localparam logic [3:0] EvSusp = 4'b0010;
  localparam logic [3:0] EvRes  = 4'b0100;
  localparam logic [3:0] EvDisc = 4'b1000;

`ifdef USBDEV_LINE_EVENT_SE1_ERR_EN
  localparam logic Se1On = 1'b1;
`else
  localparam logic Se1On = 1'b0;
`endif

  logic       clk, rst_n;
  logic       dp, dn, pwr, rx_en, us_tick, se1_clr;
  logic [1:0] line_state;
  logic [2:0] link_state;
  logic       bus_reset, suspend, evt_reset, evt_suspend, evt_resume, evt_disconnect, se1_err;

  usbdev_line_event_det #(
    .FiltCycles(3),
    .ResetUs   (3),
    .SuspendUs (20)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .usb_rx_dp_i     (dp),
    .usb_rx_dn_i     (dn),
    .usb_pwr_sense_i (pwr),
    .rx_enable_i     (rx_en),
    .us_tick_i       (us_tick),
    .se1_clr_i       (se1_clr),
    .line_state_o    (line_state),
    .link_state_o    (link_state),
    .bus_reset_o     (bus_reset),
    .suspend_o       (suspend),
    .evt_reset_o     (evt_reset),
    .evt_suspend_o   (evt_suspend),
    .evt_resume_o    (evt_resume),
    .evt_disconnect_o(evt_disconnect),
    .se1_err_o       (se1_err)
  );

  typedef struct {
    logic [1:0] line;
    logic [2:0] link;
    logic [3:0] evt;
    logic       br;
    logic       sp;
    logic       se1;
    int         ticks;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_obs = 0;
  bit   mon_en = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int div;
    div     = 0;
    us_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div     = (div == TickP - 1) ? 0 : div + 1;
      us_tick = (div == 0);
    end
  end

  task automatic push(input logic [1:0] l, input logic [2:0] k, input logic [3:0] e,
                      input logic br, input logic sp, input logic se, input int t);
    exp_t x;
    x.line = l; x.link = k; x.evt = e; x.br = br; x.sp = sp; x.se1 = se; x.ticks = t;
    sb.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: any output change or event pulse is one observation, matched in order
  initial begin
    logic [1:0] p_line;
    logic [2:0] p_link;
    logic       p_se1;
    logic [3:0] evt;
    int         acc;
    exp_t       x;
    p_line = Se0; p_link = Disc; p_se1 = 1'b0; acc = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        acc = 0;
      end else begin
        evt = {evt_disconnect, evt_resume, evt_suspend, evt_reset};
        if ((line_state != p_line) || (link_state != p_link) || (se1_err != p_se1) || (evt != 4'b0)) begin
          n_obs++;
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_obs%0d: got line=%0d link=%0d evt=%b br=%b sp=%b se1=%b, none expected",
                     n_obs, line_state, link_state, evt, bus_reset, suspend, se1_err);
          end else begin
            x = sb.pop_front();
            if ({line_state, link_state, evt, bus_reset, suspend, se1_err} !==
                {x.line, x.link, x.evt, x.br, x.sp, x.se1}) begin
              n_err++;
              $display("FAIL obs%0d: got line=%0d link=%0d evt=%b br=%b sp=%b se1=%b, expected line=%0d link=%0d evt=%b br=%b sp=%b se1=%b",
                       n_obs, line_state, link_state, evt, bus_reset, suspend, se1_err,
                       x.line, x.link, x.evt, x.br, x.sp, x.se1);
            end
            if (x.ticks >= 0) begin
              n_cmp++;
              if (acc != x.ticks) begin
                n_err++;
                $display("FAIL obs%0d_ticks: got %0d us ticks since previous change, expected %0d",
                         n_obs, acc, x.ticks);
              end
            end
          end
          acc = 0;
        end
        p_line = line_state; p_link = link_state; p_se1 = se1_err;
      end
      if (us_tick) acc++;
    end
  end

  initial begin
    rst_n = 1'b1; dp = 1'b0; dn = 1'b0; pwr = 1'b0; rx_en = 1'b1; se1_clr = 1'b0;
    #3 rst_n = 1'b0;
    #2;
    check_val("rst_line", 8'(line_state), 8'(Se0));
    check_val("rst_link", 8'(link_state), 8'(Disc));
    check_val("rst_evts", 8'({evt_disconnect, evt_resume, evt_suspend, evt_reset}), 8'h0);
    check_val("rst_bus_reset", 8'(bus_reset), 8'h0);
    check_val("rst_suspend", 8'(suspend), 8'h0);
    check_val("rst_se1", 8'(se1_err), 8'h0);
    cyc(3);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cyc(5);

    // J idle while unpowered, then power up and let it suspend; a 2-cycle K glitch must be invisible
    push(J, Disc, EvNone, 1'b0, 1'b0, 1'b0, -1);
    dp = 1'b1; cyc(10);
    push(J, Act, EvNone, 1'b0, 1'b0, 1'b0, -1);
    push(J, Susp, EvSusp, 1'b0, 1'b1, 1'b0, 20);
    pwr = 1'b1; cyc(40);
    dp = 1'b0; dn = 1'b1; cyc(2);
    dp = 1'b1; dn = 1'b0; cyc(250);

    // Resume: K, then a short SE0, then J
    push(K, Susp, EvNone, 1'b0, 1'b1, 1'b0, -1);
    push(K, Resm, EvNone, 1'b0, 1'b1, 1'b0, -1);
    dp = 1'b0; dn = 1'b1; cyc(30);
    push(Se0, Resm, EvNone, 1'b0, 1'b1, 1'b0, -1);
    push(Se0, Act, EvRes, 1'b0, 1'b0, 1'b0, -1);
    push(J, Act, EvNone, 1'b0, 1'b0, 1'b0, -1);
    dn = 1'b0; cyc(4);
    dp = 1'b1; cyc(12);

    // Bus reset after the 3rd tick of filtered SE0, released by J without extra pulses
    push(Se0, Act, EvNone, 1'b0, 1'b0, 1'b0, -1);
    push(Se0, Rst, EvRst, 1'b1, 1'b0, 1'b0, 3);
    dp = 1'b0; cyc(40);
    push(J, Rst, EvNone, 1'b1, 1'b0, 1'b0, -1);
    push(J, Act, EvNone, 1'b0, 1'b0, 1'b0, -1);
    dp = 1'b1; cyc(12);

    // Power loss during reset
    push(Se0, Act, EvNone, 1'b0, 1'b0, 1'b0, -1);
    push(Se0, Rst, EvRst, 1'b1, 1'b0, 1'b0, 3);
    dp = 1'b0; cyc(40);
    push(Se0, Disc, EvDisc, 1'b0, 1'b0, 1'b0, -1);
    pwr = 1'b0; cyc(5);
    push(J, Disc, EvNone, 1'b0, 1'b0, 1'b0, -1);
    dp = 1'b1; cyc(10);
    push(J, Act, EvNone, 1'b0, 1'b0, 1'b0, -1);
    pwr = 1'b1; cyc(10);

    // Receiver disable behaves like power loss
    push(J, Disc, EvDisc, 1'b0, 1'b0, 1'b0, -1);
    rx_en = 1'b0; cyc(5);
    push(J, Act, EvNone, 1'b0, 1'b0, 1'b0, -1);
    rx_en = 1'b1; cyc(5);

    // SE1 for 5 samples: link unchanged, sticky flag only when enabled
    push(Se1, Act, EvNone, 1'b0, 1'b0, 1'b0, -1);
    if (Se1On) push(Se1, Act, EvNone, 1'b0, 1'b0, 1'b1, -1);
    push(J, Act, EvNone, 1'b0, 1'b0, Se1On, -1);
    dn = 1'b1; cyc(5);
    dn = 1'b0; cyc(10);
    if (Se1On) push(J, Act, EvNone, 1'b0, 1'b0, 1'b0, -1);
    se1_clr = 1'b1; cyc(1);
    se1_clr = 1'b0; cyc(10);

    // Asynchronous reset in the middle of a cycle
    mon_en = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_line", 8'(line_state), 8'(Se0));
    check_val("async_link", 8'(link_state), 8'(Disc));
    check_val("async_evts", 8'({evt_disconnect, evt_resume, evt_suspend, evt_reset}), 8'h0);
    check_val("async_flags", 8'({bus_reset, suspend, se1_err}), 8'h0);
    check_val("sb_left", 8'(sb.size()), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
